// File: rtl/knn_pkg.sv
// Shared KNN definitions: vote FSM state encoding and a constant-foldable clog2 used for width derivation.
package knn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_SELECT,
        ST_DONE
    } knn_state_e;

    function automatic int knn_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/knn_vote_argmax.sv
// Running arg-max over per-class vote counts; ties resolve to the class whose first vote came from the nearer rank.
module knn_vote_argmax
    import knn_pkg::*;
#(
    parameter int TYPE_W = 2,
    parameter int VW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_en,
    input  logic [TYPE_W-1:0] i_class,
    input  logic [VW-1:0]     i_cnt,
    input  logic [VW-1:0]     i_rank,
    output logic [TYPE_W-1:0] o_best_class,
    output logic [VW-1:0]     o_best_cnt
);

    logic [TYPE_W-1:0] r_best_class;
    logic [VW-1:0]     r_best_cnt;
    logic [VW-1:0]     r_best_rank;
    logic              w_take;

    // A zero count never wins a tie, so an all-empty scan leaves class 0 with zero votes.
    assign w_take = (i_cnt > r_best_cnt) ||
                    ((i_cnt == r_best_cnt) && (i_cnt != '0) && (i_rank < r_best_rank));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_best_class <= '0;
            r_best_cnt   <= '0;
            r_best_rank  <= '1;
        end else if (i_init) begin
            r_best_class <= '0;
            r_best_cnt   <= '0;
            r_best_rank  <= '1;
        end else if (i_en && w_take) begin
            r_best_class <= i_class;
            r_best_cnt   <= i_cnt;
            r_best_rank  <= i_rank;
        end
    end

    assign o_best_class = r_best_class;
    assign o_best_cnt   = r_best_cnt;

endmodule

// File: rtl/knn_vote.sv
// KNN majority vote over the K nearest sorted entries; fixed K+C+1 cycle latency from capture to class_valid.
// Optional distance gating via KNN_VOTE_DIST_THRESH_EN (adds max_dist input and reject output).
module knn_vote
    import knn_pkg::*;
#(
    parameter int L      = 3,
    parameter int W      = 16,
    parameter int TYPE_W = 2,
    parameter int K      = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_sort,
    input  logic [W*(1<<L)-1:0]           distance_array_sorted,
    input  logic [TYPE_W*(1<<L)-1:0]      type_array_sorted,
`ifdef KNN_VOTE_DIST_THRESH_EN
    input  logic [W-1:0]                  max_dist,
    output logic                          reject,
`endif
    output logic                          in_ready,
    output logic [TYPE_W-1:0]             class_out,
    output logic [knn_clog2(K+1)-1:0]     vote_count,
    output logic                          class_valid,
    output logic                          overrun
);

    localparam int N  = 1 << L;
    localparam int C  = 1 << TYPE_W;
    localparam int VW = knn_clog2(K + 1);
    localparam int IW = (VW > TYPE_W) ? VW : TYPE_W;

    generate
        if (K < 1 || K > N) begin : g_bad_k
            $error("knn_vote: K must lie in 1..N");
        end
    endgenerate

    knn_state_e        r_state;
    knn_state_e        w_next;
    logic [TYPE_W-1:0] r_types [K];
    logic [VW-1:0]     r_cnt [C];
    logic [VW-1:0]     r_first_rank [C];
    logic [IW-1:0]     r_idx;
    logic              w_capture;
    logic              w_last_count;
    logic              w_last_select;
    logic [TYPE_W-1:0] w_type;
    logic              w_qualify;
    logic [VW-1:0]     w_sel_cnt;
    logic [VW-1:0]     w_sel_rank;
    logic [TYPE_W-1:0] w_best_class;
    logic [VW-1:0]     w_best_cnt;
    logic              r_class_valid;
    logic              r_overrun;
    logic [TYPE_W-1:0] r_class_out;
    logic [VW-1:0]     r_vote_count;
    logic              w_unused_bits;
`ifdef KNN_VOTE_DIST_THRESH_EN
    logic [W-1:0]      r_dists [K];
    logic [W-1:0]      r_max_dist;
    logic [W-1:0]      w_dist;
    logic              r_reject;
`endif

    // Entries beyond K (and distances in the ungated build) are intentionally ignored.
    assign w_unused_bits = ^{type_array_sorted, distance_array_sorted};

    assign w_capture     = (r_state == ST_IDLE) && valid_sort;
    assign w_last_count  = (r_idx == IW'(K - 1));
    assign w_last_select = (r_idx == IW'(C - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (valid_sort)    w_next = ST_COUNT;
            ST_COUNT:  if (w_last_count)  w_next = ST_SELECT;
            ST_SELECT: if (w_last_select) w_next = ST_DONE;
            ST_DONE:                      w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < K; r++) begin
                r_types[r] <= '0;
`ifdef KNN_VOTE_DIST_THRESH_EN
                r_dists[r] <= '0;
`endif
            end
`ifdef KNN_VOTE_DIST_THRESH_EN
            r_max_dist <= '0;
`endif
        end else if (w_capture) begin
            for (int r = 0; r < K; r++) begin
                r_types[r] <= type_array_sorted[TYPE_W*r +: TYPE_W];
`ifdef KNN_VOTE_DIST_THRESH_EN
                r_dists[r] <= distance_array_sorted[W*r +: W];
`endif
            end
`ifdef KNN_VOTE_DIST_THRESH_EN
            r_max_dist <= max_dist;
`endif
        end
    end

    // Entry r_idx of the latched arrays and whether it may vote.
    always_comb begin
        w_type    = '0;
        w_qualify = 1'b1;
`ifdef KNN_VOTE_DIST_THRESH_EN
        w_dist = '0;
`endif
        for (int r = 0; r < K; r++) begin
            if (r_idx == IW'(r)) begin
                w_type = r_types[r];
`ifdef KNN_VOTE_DIST_THRESH_EN
                w_dist = r_dists[r];
`endif
            end
        end
`ifdef KNN_VOTE_DIST_THRESH_EN
        w_qualify = (w_dist <= r_max_dist);
`endif
    end

    always_comb begin
        w_sel_cnt  = '0;
        w_sel_rank = '0;
        for (int c = 0; c < C; c++) begin
            if (r_idx == IW'(c)) begin
                w_sel_cnt  = r_cnt[c];
                w_sel_rank = r_first_rank[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < C; c++) begin
                r_cnt[c]        <= '0;
                r_first_rank[c] <= '0;
            end
        end else if (w_capture) begin
            for (int c = 0; c < C; c++) begin
                r_cnt[c]        <= '0;
                r_first_rank[c] <= '0;
            end
        end else if (r_state == ST_COUNT && w_qualify) begin
            for (int c = 0; c < C; c++) begin
                if (w_type == TYPE_W'(c)) begin
                    if (r_cnt[c] == '0) begin
                        r_first_rank[c] <= VW'(r_idx);
                    end
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    // One index walks the ranks in COUNT and then the classes in SELECT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= '0;
        end else if (r_state == ST_COUNT) begin
            r_idx <= w_last_count ? '0 : r_idx + 1'b1;
        end else if (r_state == ST_SELECT) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    knn_vote_argmax #(
        .TYPE_W (TYPE_W),
        .VW     (VW)
    ) u_argmax (
        .clk          (clk),
        .rst          (rst),
        .i_init       (w_capture),
        .i_en         (r_state == ST_SELECT),
        .i_class      (TYPE_W'(r_idx)),
        .i_cnt        (w_sel_cnt),
        .i_rank       (w_sel_rank),
        .o_best_class (w_best_class),
        .o_best_cnt   (w_best_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_class_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_class_out   <= '0;
            r_vote_count  <= '0;
`ifdef KNN_VOTE_DIST_THRESH_EN
            r_reject      <= 1'b0;
`endif
        end else begin
            r_class_valid <= (r_state == ST_DONE);
            r_overrun     <= valid_sort && (r_state != ST_IDLE);
            if (r_state == ST_DONE) begin
                r_class_out  <= w_best_class;
                r_vote_count <= w_best_cnt;
`ifdef KNN_VOTE_DIST_THRESH_EN
                r_reject     <= (w_best_cnt == '0);
`endif
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign class_out   = r_class_out;
    assign vote_count  = r_vote_count;
    assign class_valid = r_class_valid;
    assign overrun     = r_overrun;
`ifdef KNN_VOTE_DIST_THRESH_EN
    assign reject      = r_reject;
`endif

endmodule

// File: tb/tb_knn_vote.sv
// Directed self-checking bench for knn_vote (L=3, K=5, TYPE_W=2, W=16); threshold cases under KNN_VOTE_DIST_THRESH_EN.
module tb_knn_vote;

    localparam int L      = 3;
    localparam int W      = 16;
    localparam int TYPE_W = 2;
    localparam int K      = 5;
    localparam int N      = 1 << L;

    logic                 clk;
    logic                 rst;
    logic                 valid_sort;
    logic [W*N-1:0]       distance_array_sorted;
    logic [TYPE_W*N-1:0]  type_array_sorted;
    logic                 in_ready;
    logic [TYPE_W-1:0]    class_out;
    logic [2:0]           vote_count;
    logic                 class_valid;
    logic                 overrun;
`ifdef KNN_VOTE_DIST_THRESH_EN
    logic [W-1:0]         maxDist;
    logic                 reject;
`endif

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;
    int cyc;
    int seen;
    logic [W*N-1:0] defaultDist;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    knn_vote #(
        .L      (L),
        .W      (W),
        .TYPE_W (TYPE_W),
        .K      (K)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .valid_sort            (valid_sort),
        .distance_array_sorted (distance_array_sorted),
        .type_array_sorted     (type_array_sorted),
`ifdef KNN_VOTE_DIST_THRESH_EN
        .max_dist              (maxDist),
        .reject                (reject),
`endif
        .in_ready              (in_ready),
        .class_out             (class_out),
        .vote_count            (vote_count),
        .class_valid           (class_valid),
        .overrun               (overrun)
    );

    function automatic logic [TYPE_W*N-1:0] packT(input int a0, input int a1, input int a2, input int a3,
                                                  input int a4, input int a5, input int a6, input int a7);
        int a [8];
        logic [TYPE_W*N-1:0] v;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        v = '0;
        for (int i = 0; i < N; i++) v[TYPE_W*i +: TYPE_W] = a[i][TYPE_W-1:0];
        return v;
    endfunction

    function automatic logic [W*N-1:0] packD(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
        int a [8];
        logic [W*N-1:0] v;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        v = '0;
        for (int i = 0; i < N; i++) v[W*i +: W] = a[i][W-1:0];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle valid_sort pulse; returns at the negedge right after the capture edge.
    task automatic applyStimulus(input logic [TYPE_W*N-1:0] t, input logic [W*N-1:0] d);
        @(negedge clk);
        type_array_sorted     = t;
        distance_array_sorted = d;
        valid_sort            = 1'b1;
        @(negedge clk);
        valid_sort            = 1'b0;
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (class_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst                   = 1'b0;
        valid_sort            = 1'b0;
        type_array_sorted     = '0;
        distance_array_sorted = '0;
`ifdef KNN_VOTE_DIST_THRESH_EN
        maxDist               = '1;
`endif
        defaultDist = packD(10, 20, 30, 40, 50, 60, 70, 80);

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_class_valid", class_valid, 0);
        checkOutput("reset_class_out", class_out, 0);
        checkOutput("reset_vote_count", vote_count, 0);
        checkOutput("reset_overrun", overrun, 0);
        rst = 1'b1;

        $display("[TB] plain majority");
        applyStimulus(packT(1, 1, 1, 2, 3, 0, 0, 0), defaultDist);
        checkOutput("busy_in_ready", in_ready, 0);
        waitResult(cyc);
        checkOutput("maj_latency", cyc, 10);
        checkOutput("maj_valid", class_valid, 1);
        checkOutput("maj_class", class_out, 1);
        checkOutput("maj_votes", vote_count, 3);
        @(negedge clk);
        checkOutput("maj_pulse_low", class_valid, 0);
        checkOutput("maj_class_held", class_out, 1);
        checkOutput("maj_idle_ready", in_ready, 1);

        $display("[TB] tie to nearest (higher class)");
        applyStimulus(packT(2, 1, 2, 1, 3, 0, 0, 0), defaultDist);
        waitResult(cyc);
        checkOutput("tie2_latency", cyc, 10);
        checkOutput("tie2_class", class_out, 2);
        checkOutput("tie2_votes", vote_count, 2);

        $display("[TB] tie to nearest (lower class)");
        applyStimulus(packT(1, 2, 1, 2, 0, 3, 3, 3), defaultDist);
        waitResult(cyc);
        checkOutput("tie1_class", class_out, 1);
        checkOutput("tie1_votes", vote_count, 2);

        $display("[TB] unanimous, tail entries ignored");
        applyStimulus(packT(0, 0, 0, 0, 0, 3, 3, 3), defaultDist);
        waitResult(cyc);
        checkOutput("all0_valid", class_valid, 1);
        checkOutput("all0_class", class_out, 0);
        checkOutput("all0_votes", vote_count, 5);

        $display("[TB] overrun during COUNT");
        applyStimulus(packT(3, 3, 0, 1, 2, 0, 0, 0), defaultDist);
        @(negedge clk);
        type_array_sorted = packT(0, 0, 0, 0, 0, 0, 0, 0);
        valid_sort        = 1'b1;
        @(negedge clk);
        checkOutput("overrun_high", overrun, 1);
        valid_sort = 1'b0;
        @(negedge clk);
        checkOutput("overrun_low", overrun, 0);
        waitResult(cyc);
        checkOutput("overrun_latency", cyc + 3, 10);
        checkOutput("overrun_class", class_out, 3);
        checkOutput("overrun_votes", vote_count, 2);

        $display("[TB] reset during SELECT");
        applyStimulus(packT(2, 2, 2, 0, 1, 0, 0, 0), defaultDist);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_class_out", class_out, 0);
        checkOutput("midrst_votes", vote_count, 0);
        checkOutput("midrst_valid", class_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (class_valid === 1'b1) seen = 1;
        end
        checkOutput("midrst_no_valid", seen, 0);
        applyStimulus(packT(1, 1, 1, 2, 3, 0, 0, 0), defaultDist);
        waitResult(cyc);
        checkOutput("post_rst_latency", cyc, 10);
        checkOutput("post_rst_class", class_out, 1);
        checkOutput("post_rst_votes", vote_count, 3);

`ifdef KNN_VOTE_DIST_THRESH_EN
        $display("[TB] distance threshold");
        maxDist = 16'd50;
        applyStimulus(packT(3, 0, 0, 0, 0, 0, 0, 0), packD(10, 20, 60, 70, 80, 90, 100, 110));
        maxDist = 16'd0;
        waitResult(cyc);
        checkOutput("thr_latency", cyc, 10);
        checkOutput("thr_class", class_out, 3);
        checkOutput("thr_votes", vote_count, 1);
        checkOutput("thr_reject", reject, 0);
        maxDist = 16'd5;
        applyStimulus(packT(3, 0, 0, 0, 0, 0, 0, 0), packD(10, 20, 60, 70, 80, 90, 100, 110));
        waitResult(cyc);
        checkOutput("rej_class", class_out, 0);
        checkOutput("rej_votes", vote_count, 0);
        checkOutput("rej_reject", reject, 1);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
